mmio_data_bus: RTL and testbench

//  Data-side interconnect between the MIPS32 single-cycle core and data_memory.
//  - Splits the core's data port into a RAM region and a memory-mapped I/O window.
//  - Replaces the single hard-wired info word with N_INFO writable output registers.
//  - Adds a free-running cycle counter and an optional compare timer.
//  - Sits inside the top-level computer, between the core's adm/wddm/we/rddm and data_memory.

---
 rtl/mmio_data_bus_if.sv | 31 +++
 rtl/mmio_data_bus.sv | 148 ++++++++++++++
 tb/tb_mmio_data_bus.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_data_bus_if.sv
// ============================================================================
// Module   : mmio_data_bus_if
// Brief    : Core data port and data_memory port bundled for mmio_data_bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mmio_data_bus_if;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic [31:0] cpu_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    // Core and memory side: drives requests and RAM read data
    modport master (
        output cpu_addr, cpu_wdata, cpu_we, mem_rdata,
        input  cpu_rdata, mem_addr, mem_wdata, mem_we
    );

    // Interconnect side
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, mem_rdata,
        output cpu_rdata, mem_addr, mem_wdata, mem_we
    );
endinterface

`default_nettype wire

// File: rtl/mmio_data_bus.sv
// ============================================================================
// Module   : mmio_data_bus
// Brief    : Data-side RAM/MMIO splitter with info registers, cycle counter and
//            optional compare timer (enabled by defining MMIO_TIMER_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module mmio_data_bus #(
    parameter int          N_INFO    = 4,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter logic [31:0] INFO_RST  = 32'h0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    mmio_data_bus_if.slave         bus,
    output logic [32*N_INFO-1:0]   info,
    output logic                   timer_irq
);

    localparam logic [13:0] c_word_cycle  = 14'h020;
`ifdef MMIO_TIMER_EN
    localparam logic [13:0] c_word_tcmp   = 14'h021;
    localparam logic [13:0] c_word_tctrl  = 14'h022;
    localparam logic [13:0] c_word_tstat  = 14'h023;
    localparam logic [13:0] c_word_tcount = 14'h024;
`endif

    logic        w_mmio;
    logic [13:0] w_word;
    logic        w_wr;
    logic        w_info_hit;
    logic [31:0] w_mmio_rdata;

    logic [31:0] r_info [N_INFO];
    logic [31:0] r_cycle;

    assign w_mmio     = (bus.cpu_addr[31:16] == MMIO_BASE[31:16]);
    assign w_word     = bus.cpu_addr[15:2];
    assign w_wr       = w_mmio && bus.cpu_we;
    assign w_info_hit = (w_word[13:5] == 9'd0) && ({1'b0, w_word[4:0]} < 6'(N_INFO));

    assign bus.mem_addr  = bus.cpu_addr;
    assign bus.mem_wdata = bus.cpu_wdata;
    assign bus.mem_we    = bus.cpu_we && !w_mmio;
    assign bus.cpu_rdata = w_mmio ? w_mmio_rdata : bus.mem_rdata;

    generate
        for (genvar gi = 0; gi < N_INFO; gi++) begin : g_info
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_info[gi] <= INFO_RST;
                end else if (w_wr && w_info_hit && (w_word[4:0] == 5'(gi))) begin
                    r_info[gi] <= bus.cpu_wdata;
                end
            end
            assign info[32*gi +: 32] = r_info[gi];
        end
    endgenerate

    // Any write to CYCLE restarts it from zero, taking priority over the increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle <= 32'h0;
        end else if (w_wr && (w_word == c_word_cycle)) begin
            r_cycle <= 32'h0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

`ifdef MMIO_TIMER_EN
    logic [31:0] r_tcmp;
    logic [31:0] r_tcount;
    logic        r_en;
    logic        r_autoreload;
    logic        r_expired;
    logic        w_expire;

    assign w_expire = r_en && (r_tcount == r_tcmp);

    // Later assignments win: CPU writes override the timer step, expiry beats W1C
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcmp       <= 32'h0;
            r_tcount     <= 32'h0;
            r_en         <= 1'b0;
            r_autoreload <= 1'b0;
            r_expired    <= 1'b0;
        end else begin
            if (r_en) begin
                if (r_tcount != r_tcmp) begin
                    r_tcount <= r_tcount + 32'd1;
                end else if (r_autoreload) begin
                    r_tcount <= 32'h0;
                end else begin
                    r_en <= 1'b0;
                end
            end
            if (w_wr && (w_word == c_word_tcmp)) begin
                r_tcmp <= bus.cpu_wdata;
            end
            if (w_wr && (w_word == c_word_tctrl)) begin
                r_en         <= bus.cpu_wdata[0];
                r_autoreload <= bus.cpu_wdata[1];
            end
            if (w_wr && (w_word == c_word_tcount)) begin
                r_tcount <= bus.cpu_wdata;
            end
            if (w_wr && (w_word == c_word_tstat) && bus.cpu_wdata[0]) begin
                r_expired <= 1'b0;
            end
            if (w_expire) begin
                r_expired <= 1'b1;
            end
        end
    end

    assign timer_irq = r_expired;
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        w_mmio_rdata = 32'h0;
        if (w_info_hit) begin
            for (int i = 0; i < N_INFO; i++) begin
                if (w_word[4:0] == 5'(i)) begin
                    w_mmio_rdata = r_info[i];
                end
            end
        end else begin
            case (w_word)
                c_word_cycle:  w_mmio_rdata = r_cycle;
`ifdef MMIO_TIMER_EN
                c_word_tcmp:   w_mmio_rdata = r_tcmp;
                c_word_tctrl:  w_mmio_rdata = {30'h0, r_autoreload, r_en};
                c_word_tstat:  w_mmio_rdata = {31'h0, r_expired};
                c_word_tcount: w_mmio_rdata = r_tcount;
`endif
                default:       w_mmio_rdata = 32'h0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mmio_data_bus.sv
// ============================================================================
// Module   : tb_mmio_data_bus
// Brief    : Directed self-checking bench for mmio_data_bus with a small RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mmio_data_bus;
    localparam int          N_INFO  = 4;
    localparam logic [31:0] BASE    = 32'hFFFF_0000;
    localparam logic [31:0] IRST    = 32'hA5A5_0001;
    localparam logic [31:0] A_CYCLE = 32'hFFFF_0080;
    localparam logic [31:0] A_TCMP  = 32'hFFFF_0084;
    localparam logic [31:0] A_TCTRL = 32'hFFFF_0088;
    localparam logic [31:0] A_TSTAT = 32'hFFFF_008C;
    localparam logic [31:0] A_TCNT  = 32'hFFFF_0090;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [32*N_INFO-1:0]  info;
    logic                  timer_irq;
    int                    checks = 0;
    int                    errors = 0;
    logic [31:0]           ram [0:255];

    mmio_data_bus_if bus_if ();

    mmio_data_bus #(.N_INFO(N_INFO), .MMIO_BASE(BASE), .INFO_RST(IRST)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .info      (info),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus_if.mem_we) ram[bus_if.mem_addr[9:2]] <= bus_if.mem_wdata;
    end
    assign bus_if.mem_rdata = ram[bus_if.mem_addr[9:2]];

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.cpu_addr = a; bus_if.cpu_wdata = d; bus_if.cpu_we = 1'b1;
        @(posedge clk);
        #1 bus_if.cpu_we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_if.cpu_addr = a; bus_if.cpu_we = 1'b0;
        #1 d = bus_if.cpu_rdata;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rst = 1'b1;
        bus_if.cpu_addr = BASE; bus_if.cpu_wdata = 32'h1111_2222; bus_if.cpu_we = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus_if.mem_we !== 1'b0) begin
            errors++; $display("FAIL reset_mem_we got %b want 0", bus_if.mem_we);
        end
        @(negedge clk); rst = 1'b0; bus_if.cpu_we = 1'b0;
        #1;
        checks++;
        if (info !== {N_INFO{IRST}}) begin
            errors++; $display("FAIL reset_info got %h want %h", info, {N_INFO{IRST}});
        end
        checks++;
        if (timer_irq !== 1'b0) begin
            errors++; $display("FAIL reset_irq got %b want 0", timer_irq);
        end
        bus_if.cpu_addr = A_CYCLE; #1 v = bus_if.cpu_rdata;
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL reset_cycle got %h want 0", v);
        end
    endtask

    task automatic test_ram_and_info;
        logic [31:0] v;
        wr(32'h0000_0004, 32'h5555_AAAA);
        @(negedge clk);
        bus_if.cpu_addr = 32'h0000_0010; bus_if.cpu_wdata = 32'h1234; bus_if.cpu_we = 1'b1;
        #1;
        checks++;
        if (bus_if.mem_we !== 1'b1) begin
            errors++; $display("FAIL ram_mem_we got %b want 1", bus_if.mem_we);
        end
        @(posedge clk); #1 bus_if.cpu_we = 1'b0;
        rd(32'h0000_0010, v);
        checks++;
        if (v !== 32'h1234) begin
            errors++; $display("FAIL ram_readback got %h want 00001234", v);
        end
        @(negedge clk);
        bus_if.cpu_addr = 32'hFFFF_0004; bus_if.cpu_wdata = 32'hCAFE; bus_if.cpu_we = 1'b1;
        #1;
        checks++;
        if (bus_if.mem_we !== 1'b0) begin
            errors++; $display("FAIL mmio_mem_we got %b want 0", bus_if.mem_we);
        end
        @(posedge clk); #1 bus_if.cpu_we = 1'b0;
        checks++;
        if (info !== {IRST, IRST, 32'hCAFE, IRST}) begin
            errors++; $display("FAIL info1_write got %h want %h", info, {IRST, IRST, 32'hCAFE, IRST});
        end
        rd(32'hFFFF_0004, v);
        checks++;
        if (v !== 32'hCAFE) begin
            errors++; $display("FAIL info1_read got %h want 0000cafe", v);
        end
        rd(32'h0000_0004, v);
        checks++;
        if (v !== 32'h5555_AAAA) begin
            errors++; $display("FAIL ram_untouched got %h want 5555aaaa", v);
        end
    endtask

    task automatic test_cycle;
        logic [31:0] a, b;
        rd(A_CYCLE, a);
        repeat (10) @(negedge clk);
        #1 b = bus_if.cpu_rdata;
        checks++;
        if (b - a !== 32'd10) begin
            errors++; $display("FAIL cycle_delta got %0d want 10", b - a);
        end
        wr(A_CYCLE, 32'h1234_5678);
        rd(A_CYCLE, a);
        checks++;
        if (a !== 32'h0) begin
            errors++; $display("FAIL cycle_clear got %h want 0", a);
        end
        rd(A_CYCLE, a);
        checks++;
        if (a !== 32'h1) begin
            errors++; $display("FAIL cycle_after_clear got %h want 1", a);
        end
        @(negedge clk);
        dut.r_cycle = 32'hFFFF_FFFF;
        bus_if.cpu_addr = A_CYCLE;
        @(posedge clk); #1 a = bus_if.cpu_rdata;
        checks++;
        if (a !== 32'h0) begin
            errors++; $display("FAIL cycle_wrap got %h want 0", a);
        end
    endtask

    task automatic test_unmapped;
        logic [31:0] v;
        logic [32*N_INFO-1:0] snap;
        snap = info;
        rd(32'hFFFF_0FFC, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL unmapped_read got %h want 0", v);
        end
        rd(32'hFFFF_0010, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL info_oob_read got %h want 0", v);
        end
        wr(32'hFFFF_0FFC, 32'hDEAD_0001);
        wr(32'hFFFF_0010, 32'hBEEF_0002);
        checks++;
        if (info !== snap) begin
            errors++; $display("FAIL unmapped_write got %h want %h", info, snap);
        end
        rd(32'hFFFF_0010, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL info_oob_after got %h want 0", v);
        end
    endtask

`ifdef MMIO_TIMER_EN
    task automatic test_timer_oneshot;
        logic [31:0] v;
        int n;
        wr(A_TCMP, 32'd5);
        wr(A_TCTRL, 32'd1);
        n = 0;
        while (timer_irq !== 1'b1 && n < 20) begin
            @(posedge clk); #1 n++;
        end
        checks++;
        if (n !== 6) begin
            errors++; $display("FAIL oneshot_latency got %0d want 6", n);
        end
        rd(A_TCTRL, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL oneshot_tctrl got %h want 0", v);
        end
        rd(A_TCNT, v);
        checks++;
        if (v !== 32'd5) begin
            errors++; $display("FAIL oneshot_tcount got %h want 5", v);
        end
        wr(A_TSTAT, 32'h1);
        checks++;
        if (timer_irq !== 1'b0) begin
            errors++; $display("FAIL oneshot_w1c got %b want 0", timer_irq);
        end
    endtask

    task automatic test_timer_autoreload;
        int n;
        wr(A_TCNT, 32'd0);
        wr(A_TCMP, 32'd3);
        wr(A_TCTRL, 32'd3);
        n = 0;
        while (timer_irq !== 1'b1 && n < 20) begin
            @(posedge clk); #1 n++;
        end
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL reload_first got %0d want 4", n);
        end
        wr(A_TSTAT, 32'h1);
        n = 1;
        while (timer_irq !== 1'b1 && n < 20) begin
            @(posedge clk); #1 n++;
        end
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL reload_period got %0d want 4", n);
        end
        wr(A_TSTAT, 32'h1);
        checks++;
        if (timer_irq !== 1'b0) begin
            errors++; $display("FAIL reload_w1c got %b want 0", timer_irq);
        end
        repeat (2) @(posedge clk);
        wr(A_TSTAT, 32'h1);
        checks++;
        if (timer_irq !== 1'b1) begin
            errors++; $display("FAIL w1c_vs_expiry got %b want 1", timer_irq);
        end
    endtask
`else
    task automatic test_timer_absent;
        logic [31:0] v;
        wr(A_TCMP, 32'd2);
        wr(A_TCNT, 32'd7);
        wr(A_TCTRL, 32'd3);
        repeat (8) @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            rd(A_TCMP + 32'(4 * k), v);
            checks++;
            if (v !== 32'h0) begin
                errors++; $display("FAIL absent_read_%0d got %h want 0", k, v);
            end
        end
        checks++;
        if (timer_irq !== 1'b0) begin
            errors++; $display("FAIL absent_irq got %b want 0", timer_irq);
        end
    endtask
`endif

    task automatic test_reset_mid;
        logic [31:0] v;
        wr(BASE, 32'h0000_0077);
        @(negedge clk);
        rst = 1'b1;
        bus_if.cpu_addr = 32'hFFFF_0008; bus_if.cpu_wdata = 32'h99; bus_if.cpu_we = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; bus_if.cpu_we = 1'b0;
        #1;
        checks++;
        if (info !== {N_INFO{IRST}}) begin
            errors++; $display("FAIL midrst_info got %h want %h", info, {N_INFO{IRST}});
        end
        checks++;
        if (timer_irq !== 1'b0) begin
            errors++; $display("FAIL midrst_irq got %b want 0", timer_irq);
        end
        bus_if.cpu_addr = A_CYCLE; #1 v = bus_if.cpu_rdata;
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL midrst_cycle got %h want 0", v);
        end
`ifdef MMIO_TIMER_EN
        for (int k = 0; k < 4; k++) begin
            bus_if.cpu_addr = A_TCMP + 32'(4 * k);
            #1 v = bus_if.cpu_rdata;
            checks++;
            if (v !== 32'h0) begin
                errors++; $display("FAIL midrst_timer_%0d got %h want 0", k, v);
            end
        end
`endif
    endtask

    initial begin
        rst = 1'b0;
        bus_if.cpu_addr = 32'h0; bus_if.cpu_wdata = 32'h0; bus_if.cpu_we = 1'b0;
        @(negedge clk);
        test_reset;
        test_ram_and_info;
        test_cycle;
        test_unmapped;
`ifdef MMIO_TIMER_EN
        test_timer_oneshot;
        test_timer_autoreload;
`else
        test_timer_absent;
`endif
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
